// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, fixed-latency memory between instruction fetch and
// the data (load/store) stage. One access is in flight at a time. Data wins
// arbitration unless fetch has been passed over STARVE_MAX times in a row.
//
// Ports:
//   clk_i, rstN_i                       clock, async active-low reset
//   ifReq_i, ifAddr_i                   fetch read request and address
//   ifGnt_o, ifValid_o, ifData_o        fetch accept pulse, data-valid pulse, data
//   dReq_i, dWe_i, dAddr_i, dWdata_i    data request (load or store)
//   dGnt_o, dValid_o, dData_o           data accept pulse, done pulse, load data
//   memEn_o, memWe_o, memAddr_o,
//   memWdata_o, memRdata_i              memory command and read data
//   busy_o                              high while an access is in progress
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rstN_i,
    input  logic              ifReq_i,
    input  logic [ADDR_W-1:0] ifAddr_i,
    output logic              ifGnt_o,
    output logic              ifValid_o,
    output logic [DATA_W-1:0] ifData_o,
    input  logic              dReq_i,
    input  logic              dWe_i,
    input  logic [ADDR_W-1:0] dAddr_i,
    input  logic [DATA_W-1:0] dWdata_i,
    output logic              dGnt_o,
    output logic              dValid_o,
    output logic [DATA_W-1:0] dData_o,
    output logic              memEn_o,
    output logic              memWe_o,
    output logic [ADDR_W-1:0] memAddr_o,
    output logic [DATA_W-1:0] memWdata_o,
    input  logic [DATA_W-1:0] memRdata_i,
    output logic              busy_o
);

    localparam logic [2:0] LatInit   = 3'(MEM_LAT - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} stateT;

    stateT      state;
    logic [2:0] latCnt;
    logic [3:0] starveCnt;
    logic       ownerIsFetch;
    logic       weLatched;
    logic       grantFetch;

    // Fetch wins only when alone or when it has been starved long enough.
    assign grantFetch = ifReq_i && (!dReq_i || (starveCnt == StarveMax));

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            state        <= StIdle;
            latCnt       <= 3'd0;
            starveCnt    <= 4'd0;
            ownerIsFetch <= 1'b0;
            weLatched    <= 1'b0;
            ifGnt_o      <= 1'b0;
            ifValid_o    <= 1'b0;
            ifData_o     <= '0;
            dGnt_o       <= 1'b0;
            dValid_o     <= 1'b0;
            dData_o      <= '0;
            memEn_o      <= 1'b0;
            memWe_o      <= 1'b0;
            memAddr_o    <= '0;
            memWdata_o   <= '0;
            busy_o       <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises only its own.
            ifGnt_o   <= 1'b0;
            dGnt_o    <= 1'b0;
            ifValid_o <= 1'b0;
            dValid_o  <= 1'b0;
            memEn_o   <= 1'b0;
            memWe_o   <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (ifReq_i || dReq_i) begin
                        state        <= StIssue;
                        busy_o       <= 1'b1;
                        ownerIsFetch <= grantFetch;
                        weLatched    <= grantFetch ? 1'b0 : dWe_i;
                        memEn_o      <= 1'b1;
                        memWe_o      <= grantFetch ? 1'b0 : dWe_i;
                        memAddr_o    <= grantFetch ? ifAddr_i : dAddr_i;
                        memWdata_o   <= grantFetch ? '0 : dWdata_i;
                        ifGnt_o      <= grantFetch;
                        dGnt_o       <= !grantFetch;
                        if (!grantFetch && ifReq_i) begin
                            if (starveCnt != StarveMax) begin
                                starveCnt <= starveCnt + 4'd1;
                            end
                        end else begin
                            starveCnt <= 4'd0;
                        end
                    end
                end
                StIssue: begin
                    latCnt <= LatInit;
                    state  <= StWait;
                end
                StWait: begin
                    if (latCnt == 3'd0) begin
                        state <= StDone;
                        if (ownerIsFetch) begin
                            ifData_o  <= memRdata_i;
                            ifValid_o <= 1'b1;
                        end else begin
                            // Stores complete without touching the load data register.
                            if (!weLatched) begin
                                dData_o <= memRdata_i;
                            end
                            dValid_o <= 1'b1;
                        end
                    end else begin
                        latCnt <= latCnt - 3'd1;
                    end
                end
                StDone: begin
                    state  <= StIdle;
                    busy_o <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        ifReq, dReq, dWe;
    logic [31:0] ifAddr, dAddr, dWdata;
    logic        ifGnt, ifValid, dGnt, dValid, memEn, memWe, busy;
    logic [31:0] ifData, dData, memAddr, memWdata, memRdata;

    // Latency-only instances: fetch idle, data request shared.
    logic        zeroBit;
    logic [31:0] zeroWord;
    logic        lReq;
    logic        l1IfGnt, l1IfValid, l1DGnt, l1DValid, l1MemEn, l1MemWe, l1Busy;
    logic [31:0] l1IfData, l1DData, l1MemAddr, l1MemWdata;
    logic        l7IfGnt, l7IfValid, l7DGnt, l7DValid, l7MemEn, l7MemWe, l7Busy;
    logic [31:0] l7IfData, l7DData, l7MemAddr, l7MemWdata;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut0 (
        .clk_i(clk), .rstN_i(rstN),
        .ifReq_i(ifReq), .ifAddr_i(ifAddr), .ifGnt_o(ifGnt), .ifValid_o(ifValid),
        .ifData_o(ifData),
        .dReq_i(dReq), .dWe_i(dWe), .dAddr_i(dAddr), .dWdata_i(dWdata),
        .dGnt_o(dGnt), .dValid_o(dValid), .dData_o(dData),
        .memEn_o(memEn), .memWe_o(memWe), .memAddr_o(memAddr), .memWdata_o(memWdata),
        .memRdata_i(memRdata), .busy_o(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk_i(clk), .rstN_i(rstN),
        .ifReq_i(zeroBit), .ifAddr_i(zeroWord), .ifGnt_o(l1IfGnt), .ifValid_o(l1IfValid),
        .ifData_o(l1IfData),
        .dReq_i(lReq), .dWe_i(zeroBit), .dAddr_i(zeroWord), .dWdata_i(zeroWord),
        .dGnt_o(l1DGnt), .dValid_o(l1DValid), .dData_o(l1DData),
        .memEn_o(l1MemEn), .memWe_o(l1MemWe), .memAddr_o(l1MemAddr),
        .memWdata_o(l1MemWdata), .memRdata_i(zeroWord), .busy_o(l1Busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(7), .STARVE_MAX(4)) dut7 (
        .clk_i(clk), .rstN_i(rstN),
        .ifReq_i(zeroBit), .ifAddr_i(zeroWord), .ifGnt_o(l7IfGnt), .ifValid_o(l7IfValid),
        .ifData_o(l7IfData),
        .dReq_i(lReq), .dWe_i(zeroBit), .dAddr_i(zeroWord), .dWdata_i(zeroWord),
        .dGnt_o(l7DGnt), .dValid_o(l7DValid), .dData_o(l7DData),
        .memEn_o(l7MemEn), .memWe_o(l7MemWe), .memAddr_o(l7MemAddr),
        .memWdata_o(l7MemWdata), .memRdata_i(zeroWord), .busy_o(l7Busy)
    );

    // Memory model for dut0: data is valid only exactly 2 cycles after memEn.
    logic [3:0] memCnt;
    always @(posedge clk or negedge rstN) begin
        if (!rstN)                memCnt <= 4'd0;
        else if (memEn)           memCnt <= 4'd1;
        else if (memCnt == 4'd2)  memCnt <= 4'd0;
        else if (memCnt != 4'd0)  memCnt <= memCnt + 4'd1;
    end
    assign memRdata = (memCnt != 4'd2) ? 32'hBAD0BAD0 :
                      (memAddr == 32'h40) ? 32'h8C220004 : (memAddr ^ 32'hA5A50000);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          nGnt;
        int          cyc;
        logic [5:0]  order;
        logic        bothHigh;
        logic        sawValid;
        int          g1 [2];
        int          g7 [2];
        int          n1;
        int          n7;

        zeroBit = 1'b0; zeroWord = 32'h0; lReq = 1'b0;
        ifReq = 1'b0; ifAddr = 32'h0; dReq = 1'b0; dWe = 1'b0; dAddr = 32'h0; dWdata = 32'h0;
        rstN = 1'b1;
        #2 rstN = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_memEn", memEn, 0);
        check("rst_ifData", ifData, 0);
        check("rst_dData", dData, 0);
        check("rst_starve", dut0.starveCnt, 0);
        repeat (2) tick();
        rstN = 1'b1;
        tick();

        // Fetch read of 0x40.
        ifReq = 1'b1; ifAddr = 32'h40;
        tick();
        check("f_gnt", ifGnt, 1);
        check("f_memEn", memEn, 1);
        check("f_memAddr", memAddr, 32'h40);
        check("f_memWe", memWe, 0);
        check("f_dGnt", dGnt, 0);
        ifReq = 1'b0;
        tick();
        check("f_memEn_pulse", memEn, 0);
        tick();
        tick();
        check("f_valid", ifValid, 1);
        check("f_data", ifData, 32'h8C220004);
        tick();
        check("f_busy_low", busy, 0);
        check("f_valid_pulse", ifValid, 0);

        // Both requesters: data first, fetch afterwards.
        ifReq = 1'b1; ifAddr = 32'h44; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h100;
        tick();
        check("b_dGnt", dGnt, 1);
        check("b_ifGnt_low", ifGnt, 0);
        check("b_memAddr", memAddr, 32'h100);
        dReq = 1'b0;
        repeat (3) tick();
        check("b_dValid", dValid, 1);
        check("b_dData", dData, 32'hA5A50100);
        check("b_ifValid_low", ifValid, 0);
        tick();
        check("b_busy_low", busy, 0);
        tick();
        check("b_ifGnt", ifGnt, 1);
        check("b_fetch_addr", memAddr, 32'h44);
        ifReq = 1'b0;
        repeat (3) tick();
        check("b_ifValid", ifValid, 1);
        check("b_ifData", ifData, 32'hA5A50044);
        tick();

        // Store.
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h20; dWdata = 32'hDEADBEEF;
        tick();
        check("s_dGnt", dGnt, 1);
        check("s_memEn", memEn, 1);
        check("s_memWe", memWe, 1);
        check("s_memWdata", memWdata, 32'hDEADBEEF);
        check("s_memAddr", memAddr, 32'h20);
        dReq = 1'b0; dWe = 1'b0;
        tick();
        check("s_memEn_pulse", memEn, 0);
        repeat (2) tick();
        check("s_dValid", dValid, 1);
        check("s_dData_kept", dData, 32'hA5A50100);
        tick();

        // Starvation: both held high continuously.
        ifReq = 1'b1; ifAddr = 32'h80; dReq = 1'b1; dAddr = 32'h200;
        nGnt = 0; cyc = 0; order = 6'b0; bothHigh = 1'b0;
        while (nGnt < 6 && cyc < 60) begin
            tick();
            cyc++;
            if (ifGnt && dGnt) bothHigh = 1'b1;
            if (ifGnt || dGnt) begin
                order[nGnt] = ifGnt;
                if (ifGnt) check("starve_after_f", dut0.starveCnt, 0);
                nGnt++;
            end
        end
        check("grant_count", nGnt, 6);
        check("grant_order", order, 6'b010000);
        check("gnt_exclusive", bothHigh, 0);
        ifReq = 1'b0; dReq = 1'b0;
        repeat (12) tick();
        check("starve_idle", busy, 0);

        // Reset during WAIT of a fetch.
        ifReq = 1'b1; ifAddr = 32'h48;
        tick();
        check("r_gnt", ifGnt, 1);
        ifReq = 1'b0;
        tick();
        #2 rstN = 1'b0;
        #1;
        check("r_busy", busy, 0);
        check("r_memAddr", memAddr, 0);
        check("r_ifData", ifData, 0);
        check("r_dData", dData, 0);
        @(posedge clk);
        #1 rstN = 1'b1;
        sawValid = 1'b0;
        repeat (10) begin
            tick();
            if (ifValid || dValid) sawValid = 1'b1;
        end
        check("r_no_valid", sawValid, 0);
        check("r_busy_after", busy, 0);

        // Back-to-back loads at MEM_LAT=1 and MEM_LAT=7.
        lReq = 1'b1;
        n1 = 0; n7 = 0; g1[0] = 0; g1[1] = 0; g7[0] = 0; g7[1] = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (l1DGnt && n1 < 2) begin g1[n1] = c; n1++; end
            if (l7DGnt && n7 < 2) begin g7[n7] = c; n7++; end
        end
        lReq = 1'b0;
        check("lat1_count", n1, 2);
        check("lat7_count", n7, 2);
        check("lat1_gap", g1[1] - g1[0], 4);
        check("lat7_gap", g7[1] - g7[0], 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
